// File: rtl/system_0_irq_ctrl.sv
// Avalon-MM interrupt aggregator: per-source level/edge pending capture, masking,
// fixed-priority encoding and a registered CPU irq with post-acknowledge hold-off.
module system_0_irq_ctrl #(
    parameter int          NUM_IRQ         = 8,
    parameter logic [15:0] EDGE_DEFAULT    = 16'h0000,
    parameter logic [15:0] HOLDOFF_DEFAULT = 16'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               cpu_irq
);

    localparam logic [2:0] ADDR_RAW     = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_PENDING = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
    localparam logic [2:0] ADDR_ACK     = 3'd5;
    localparam logic [2:0] ADDR_HOLDOFF = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_sel;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] irq_in_d;
    logic [NUM_IRQ-1:0] enabled;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] w1c_clr;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] edge_chg;
    logic [15:0]        holdoff;
    logic [15:0]        holdoff_cnt;
    logic               holdoff_load;
    logic [15:0]        rd_mux;
    logic [3:0]         active_id;
    logic               active_valid;

    logic wr_en;
    logic wr_mask;
    logic wr_pending;
    logic wr_edge;
    logic wr_ack;
    logic wr_holdoff;

    assign wr_en      = chipselect & ~write_n;
    assign wr_mask    = wr_en && (address == ADDR_MASK);
    assign wr_pending = wr_en && (address == ADDR_PENDING);
    assign wr_edge    = wr_en && (address == ADDR_EDGE);
    assign wr_ack     = wr_en && (address == ADDR_ACK);
    assign wr_holdoff = wr_en && (address == ADDR_HOLDOFF);

    assign enabled  = pending & mask;
    assign rise     = irq_in & ~irq_in_d;
    assign w1c_clr  = wr_pending ? writedata[NUM_IRQ-1:0] : '0;
    assign edge_chg = wr_edge ? (writedata[NUM_IRQ-1:0] ^ edge_sel) : '0;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (wr_ack && (writedata[3:0] == 4'(i))) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    // Edge set outranks any clear in the same cycle so no event is lost;
    // flipping a source's mode discards whatever it had pending.
    always_comb begin
        pending_nxt = (~edge_sel & irq_in)
                    | (edge_sel & (rise | (pending & ~(w1c_clr | ack_clr))));
        pending_nxt = pending_nxt & ~edge_chg;
    end

    // Lowest index wins.
    always_comb begin
        active_id    = 4'd0;
        active_valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                active_id    = 4'(i);
                active_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        holdoff_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (|enabled) begin
                    state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (wr_ack) begin
                    state_nxt    = S_HOLD;
                    holdoff_load = 1'b1;
                end else if (!(|enabled)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (holdoff_cnt == 16'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            ADDR_RAW:     rd_mux = 16'(irq_in);
            ADDR_MASK:    rd_mux = 16'(mask);
            ADDR_PENDING: rd_mux = 16'(pending);
            ADDR_EDGE:    rd_mux = 16'(edge_sel);
            ADDR_ACTIVE:  rd_mux = active_valid ? {1'b1, 11'd0, active_id} : 16'h0000;
            ADDR_HOLDOFF: rd_mux = holdoff;
            default:      rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask     <= '0;
            edge_sel <= EDGE_DEFAULT[NUM_IRQ-1:0];
            holdoff  <= HOLDOFF_DEFAULT;
        end else begin
            if (wr_mask) begin
                mask <= writedata[NUM_IRQ-1:0];
            end
            if (wr_edge) begin
                edge_sel <= writedata[NUM_IRQ-1:0];
            end
            if (wr_holdoff) begin
                holdoff <= writedata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            irq_in_d <= '0;
            readdata <= 16'h0000;
        end else begin
            pending  <= pending_nxt;
            irq_in_d <= irq_in;
            readdata <= rd_mux;
        end
    end

    // The running count is snapshotted on acknowledge, so later HOLDOFF writes wait for the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cpu_irq     <= 1'b0;
            holdoff_cnt <= 16'd0;
        end else begin
            state   <= state_nxt;
            cpu_irq <= (state_nxt == S_ASSERT);
            if (holdoff_load) begin
                holdoff_cnt <= holdoff;
            end else if ((state == S_HOLD) && (holdoff_cnt != 16'd0)) begin
                holdoff_cnt <= holdoff_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_system_0_irq_ctrl.sv
// Directed bench for system_0_irq_ctrl: a one-vector-per-cycle table plus hand-written
// hold-off and mid-operation reset sequences.
module tb_system_0_irq_ctrl;

    typedef struct {
        string       name;
        logic [2:0]  addr;
        logic        wr;
        logic [15:0] wdata;
        logic [7:0]  irq;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        cpu_irq;

    int   checks;
    int   failures;
    vec_t vecs[$];

    system_0_irq_ctrl #(
        .NUM_IRQ         (8),
        .EDGE_DEFAULT    (16'h0000),
        .HOLDOFF_DEFAULT (16'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .cpu_irq    (cpu_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Drive one bus cycle, clock it, then leave sampling 1 ns after the edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic wr, input logic [15:0] wdata,
                                 input logic [7:0] irq);
        address    = addr;
        chipselect = 1'b1;
        write_n    = ~wr;
        writedata  = wdata;
        irq_in     = irq;
        @(posedge clk);
        #1;
        write_n = 1'b1;
    endtask

    task automatic addRead(input string name, input logic [2:0] addr, input logic [7:0] irq,
                           input logic [15:0] exp_rd, input logic exp_irq);
        vec_t v;
        v = '{name, addr, 1'b0, 16'h0000, irq, 1'b1, exp_rd, exp_irq};
        vecs.push_back(v);
    endtask

    task automatic addWrite(input string name, input logic [2:0] addr, input logic [15:0] wdata,
                            input logic [7:0] irq, input logic exp_irq);
        vec_t v;
        v = '{name, addr, 1'b1, wdata, irq, 1'b0, 16'h0000, exp_irq};
        vecs.push_back(v);
    endtask

    task automatic addIdle(input string name, input logic [7:0] irq, input logic exp_irq);
        vec_t v;
        v = '{name, 3'd7, 1'b0, 16'h0000, irq, 1'b0, 16'h0000, exp_irq};
        vecs.push_back(v);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_in     = 8'h00;

        // Reset-state reads; level sources follow irq_in one cycle late
        addRead ("raw_live",      3'd0, 8'h5A, 16'h005A, 1'b0);
        addRead ("pend_level_a",  3'd2, 8'h5A, 16'h005A, 1'b0);
        addRead ("pend_level_b",  3'd2, 8'h00, 16'h005A, 1'b0);
        addRead ("mask_rst",      3'd1, 8'h00, 16'h0000, 1'b0);
        addRead ("edge_rst",      3'd3, 8'h00, 16'h0000, 1'b0);
        addRead ("active_rst",    3'd4, 8'h00, 16'h0000, 1'b0);
        addRead ("holdoff_rst",   3'd6, 8'h00, 16'h0000, 1'b0);
        addRead ("addr7_zero",    3'd7, 8'h00, 16'h0000, 1'b0);
        addRead ("ack_reads0",    3'd5, 8'h00, 16'h0000, 1'b0);
        // Level source on bit 0
        addWrite("mask_1",        3'd1, 16'h0001, 8'h00, 1'b0);
        addIdle ("lvl_rise",      8'h01, 1'b0);
        addRead ("lvl_pending",   3'd2, 8'h01, 16'h0001, 1'b1);
        addRead ("lvl_active",    3'd4, 8'h01, 16'h8000, 1'b1);
        addRead ("lvl_drop",      3'd1, 8'h00, 16'h0001, 1'b1);
        addIdle ("lvl_irq_off",   8'h00, 1'b0);
        addRead ("lvl_active0",   3'd4, 8'h00, 16'h0000, 1'b0);
        // Edge source on bit 2, ack clear and set-wins
        addWrite("edge_4",        3'd3, 16'h0004, 8'h00, 1'b0);
        addWrite("mask_4",        3'd1, 16'h0004, 8'h00, 1'b0);
        addIdle ("edge_pulse",    8'h04, 1'b0);
        addRead ("edge_latched",  3'd2, 8'h00, 16'h0004, 1'b1);
        addRead ("edge_held",     3'd2, 8'h00, 16'h0004, 1'b1);
        addWrite("ack_2",         3'd5, 16'h0002, 8'h00, 1'b0);
        addRead ("ack_cleared",   3'd2, 8'h00, 16'h0000, 1'b0);
        addRead ("ack_active0",   3'd4, 8'h00, 16'h0000, 1'b0);
        addIdle ("edge_pulse2",   8'h04, 1'b0);
        addIdle ("edge_assert2",  8'h00, 1'b1);
        addWrite("ack_with_edge", 3'd5, 16'h0002, 8'h04, 1'b0);
        addRead ("set_wins",      3'd2, 8'h00, 16'h0004, 1'b0);
        addRead ("reassert",      3'd2, 8'h00, 16'h0004, 1'b1);
        addWrite("w1c_2",         3'd2, 16'h0004, 8'h00, 1'b1);
        addRead ("w1c_cleared",   3'd2, 8'h00, 16'h0000, 1'b0);
        // Priority encoding
        addWrite("edge_6",        3'd3, 16'h0006, 8'h00, 1'b0);
        addWrite("mask_6",        3'd1, 16'h0006, 8'h00, 1'b0);
        addIdle ("pulse_1_2",     8'h06, 1'b0);
        addRead ("active_1",      3'd4, 8'h00, 16'h8001, 1'b1);
        addWrite("ack_1",         3'd5, 16'h0001, 8'h00, 1'b0);
        addRead ("active_2",      3'd4, 8'h00, 16'h8002, 1'b0);
        addRead ("pend_after_a1", 3'd2, 8'h00, 16'h0004, 1'b1);
        addWrite("ack_id9",       3'd5, 16'h0009, 8'h00, 1'b0);
        addRead ("ack9_nochg",    3'd2, 8'h00, 16'h0004, 1'b0);
        addWrite("ack_in_idle",   3'd5, 16'h0002, 8'h00, 1'b1);
        addRead ("idle_ack_clr",  3'd2, 8'h00, 16'h0000, 1'b0);
        // Mode change discards pending
        addIdle ("pulse_1",       8'h02, 1'b0);
        addWrite("edge_chg",      3'd3, 16'h0004, 8'h00, 1'b1);
        addRead ("mode_cleared",  3'd2, 8'h00, 16'h0000, 1'b0);
        addRead ("edge_rb",       3'd3, 8'h00, 16'h0004, 1'b0);
        // Read-only writes and unimplemented bits
        addWrite("wr_raw",        3'd0, 16'hFFFF, 8'h00, 1'b0);
        addWrite("wr_active",     3'd4, 16'hFFFF, 8'h00, 1'b0);
        addRead ("mask_kept",     3'd1, 8'h00, 16'h0006, 1'b0);
        addWrite("mask_all",      3'd1, 16'hFFFF, 8'h00, 1'b0);
        addRead ("mask_width",    3'd1, 8'h00, 16'h00FF, 1'b0);
        addWrite("mask_4b",       3'd1, 16'h0004, 8'h00, 1'b0);
        addWrite("edge_all",      3'd3, 16'hFFFF, 8'h00, 1'b0);
        addRead ("edge_width",    3'd3, 8'h00, 16'h00FF, 1'b0);
        addWrite("edge_4b",       3'd3, 16'h0004, 8'h00, 1'b0);

        #2;
        checkOutput("rst_readdata", readdata, 16'h0000);
        checkOutput("rst_cpu_irq", {15'd0, cpu_irq}, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].addr, vecs[k].wr, vecs[k].wdata, vecs[k].irq);
            if (vecs[k].chk_rd) begin
                checkOutput({vecs[k].name, ".rd"}, readdata, vecs[k].exp_rd);
            end
            checkOutput({vecs[k].name, ".irq"}, {15'd0, cpu_irq}, {15'd0, vecs[k].exp_irq});
        end

        // Hold-off of 10: ack at edge 1, count runs 10..0, idle at edge 12, assert at edge 13
        applyStimulus(3'd6, 1'b1, 16'd10, 8'h00);
        applyStimulus(3'd6, 1'b0, 16'd0, 8'h00);
        checkOutput("holdoff_rb", readdata, 16'h000A);
        applyStimulus(3'd7, 1'b0, 16'd0, 8'h04);
        applyStimulus(3'd7, 1'b0, 16'd0, 8'h00);
        checkOutput("ho_pre_assert", {15'd0, cpu_irq}, 16'h0001);
        applyStimulus(3'd5, 1'b1, 16'h0002, 8'h00);
        checkOutput("ho_cyc1", {15'd0, cpu_irq}, 16'h0000);
        applyStimulus(3'd6, 1'b1, 16'd3, 8'h04);
        checkOutput("ho_cyc2", {15'd0, cpu_irq}, 16'h0000);
        for (int c = 3; c <= 12; c++) begin
            applyStimulus(3'd7, 1'b0, 16'd0, 8'h00);
            checkOutput($sformatf("ho_cyc%0d", c), {15'd0, cpu_irq}, 16'h0000);
        end
        applyStimulus(3'd7, 1'b0, 16'd0, 8'h00);
        checkOutput("ho_release", {15'd0, cpu_irq}, 16'h0001);
        applyStimulus(3'd6, 1'b0, 16'd0, 8'h00);
        checkOutput("holdoff_new", readdata, 16'h0003);
        applyStimulus(3'd3, 1'b0, 16'd0, 8'h00);
        checkOutput("pre_rst_rd", readdata, 16'h0004);
        checkOutput("pre_rst_irq", {15'd0, cpu_irq}, 16'h0001);

        // Asynchronous reset in the middle of a cycle
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_readdata", readdata, 16'h0000);
        checkOutput("arst_cpu_irq", {15'd0, cpu_irq}, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(3'd3, 1'b0, 16'd0, 8'h00);
        checkOutput("arst_edge", readdata, 16'h0000);
        applyStimulus(3'd6, 1'b0, 16'd0, 8'h00);
        checkOutput("arst_holdoff", readdata, 16'h0000);
        applyStimulus(3'd1, 1'b0, 16'd0, 8'h00);
        checkOutput("arst_mask", readdata, 16'h0000);
        checkOutput("arst_irq_after", {15'd0, cpu_irq}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/system_0_irq_ctrl.md
Name: system_0_irq_ctrl

Overview:
Avalon-MM slave interrupt aggregator sitting directly downstream of system_0_timer_0 and the other system_0 peripherals. It collects their irq lines into per-source pending state: level or rising-edge capture, maskable, with a fixed-priority encoder. It drives a single registered cpu_irq to the processor and applies a programmable hold-off after each acknowledge. Register file is 16-bit wide with a 3-bit word address and registered readdata.

Parameters:
NUM_IRQ, 8, number of irq inputs (1..15); bit 0 is highest priority.
EDGE_DEFAULT, 8'h00, reset value of EDGE_SEL; 1 = rising-edge source, 0 = level source.
HOLDOFF_DEFAULT, 16'd0, reset value of HOLDOFF.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
address  in  3  word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe, qualified by chipselect.
writedata  in  16  write data.
readdata  out  16  registered read data.
irq_in  in  NUM_IRQ  peripheral irq lines, synchronous to clk (timer irq on bit 0).
cpu_irq  out  1  registered interrupt request to the CPU.

Behaviour:
- Reset (async, active-high) values:
  - readdata=0, cpu_irq=0, MASK=0, PENDING=0, irq_in_d=0.
  - EDGE_SEL=EDGE_DEFAULT, HOLDOFF=HOLDOFF_DEFAULT, holdoff_cnt=0.
  - FSM=IDLE.
- Register map (unused bits read 0; writes to read-only addresses are ignored):
  - 0 RAW (RO): irq_in.
  - 1 MASK (RW): 1 = enabled.
  - 2 PENDING (RO except write-1-to-clear on edge bits).
  - 3 EDGE_SEL (RW).
  - 4 ACTIVE (RO): bit15 = valid; bits3:0 = lowest-index bit of (PENDING & MASK). Reads 0 when none are pending.
  - 5 ACK (WO): writedata[3:0] = source id to acknowledge.
  - 6 HOLDOFF (RW).
  - 7 reads 0.
- readdata latches the read mux every cycle, so data is valid 1 cycle after address is presented.
- Pending, per bit i:
  - Level source: PENDING[i] = irq_in[i] registered, 1-cycle latency. W1C and ACK have no effect on level sources.
  - Edge source: set on irq_in[i] & ~irq_in_d[i]. Cleared by a W1C to address 2 or by an ACK whose id equals i.
  - Simultaneous edge and clear in the same cycle: set wins. The event is never lost.
  - Changing EDGE_SEL[i] clears PENDING[i] on the write cycle.
- Bits i >= NUM_IRQ: PENDING, MASK and EDGE_SEL read 0.
- ACK with id >= NUM_IRQ: no pending change, but the FSM still enters HOLDOFF.
- FSM states and transitions:
  - IDLE → ASSERT when |(PENDING & MASK). cpu_irq=1 from the cycle after entry.
  - ASSERT → HOLD on any ACK write. cpu_irq=0 on the next edge. holdoff_cnt loads HOLDOFF.
  - ASSERT → IDLE if (PENDING & MASK) becomes 0 without an ACK (masked or level dropped). cpu_irq=0 the next cycle.
  - HOLD: holdoff_cnt decrements each cycle. At 0 → IDLE, re-evaluated the next cycle. With HOLDOFF=0, HOLD lasts exactly 1 cycle.
  - HOLD: new pending bits accumulate normally but cpu_irq stays 0.
  - A HOLDOFF register write during HOLD does not affect the running count.
- cpu_irq = (state == ASSERT), registered.
- Reset asserted mid-operation clears everything within the same cycle (async); operation resumes on the first edge after release.
- Priority: fixed ascending index, no rotation.

Test Plan:
- Reset then read every address → RAW=irq_in, MASK=0, EDGE_SEL=0x00, HOLDOFF=0, ACTIVE=0, all at 1-cycle read latency. cpu_irq=0.
- MASK=0x0001, EDGE_SEL=0, irq_in[0] high → PENDING=0x0001 after 1 cycle. cpu_irq=1 two cycles after the input rises. ACTIVE=0x8000. Drop irq_in[0] → cpu_irq=0 two cycles later.
- EDGE_SEL=0x04, MASK=0x04, 1-cycle pulse on irq_in[2] → PENDING=0x0004 latched and cpu_irq=1. ACK id=2 → PENDING=0, cpu_irq=0 next cycle. Pulse coincident with the ACK write → PENDING stays 0x0004.
- MASK=0x06, bits 1 and 2 pending → ACTIVE=0x8001. ACK 1 → ACTIVE=0x8002.
- HOLDOFF=10, edge source re-pulsed immediately after ACK → cpu_irq stays 0 for 11 cycles after the ACK write, then asserts.
- Assert reset during ASSERT with holdoff_cnt non-zero → cpu_irq and readdata drop to 0 asynchronously. EDGE_SEL returns to EDGE_DEFAULT.
